// File: rtl/arty_reset_sequencer.sv
// Staged reset release for downstream clock domains, gated on a stable MMCM lock.
// Domains release one at a time in index order; lock loss or an accepted soft reset re-asserts them all.
module arty_reset_sequencer #(
   parameter int P_NUM_DOMAINS        = 3,
   parameter int P_LOCK_STABLE_CYCLES = 1024,
   parameter int P_RELEASE_GAP_CYCLES = 16,
   parameter int P_SOFT_HOLD_CYCLES   = 64
) (
   input  logic                     i_clk_mhz,
   input  logic                     i_rst_mhz,
   input  logic                     i_mmcm_locked,
   input  logic                     i_soft_rst_req,
   output logic                     o_soft_rst_ack,
   output logic [P_NUM_DOMAINS-1:0] o_rst_domain,
   output logic                     o_seq_done,
   output logic                     o_lock_lost
);

   localparam int C_MAX_A = (P_LOCK_STABLE_CYCLES > P_RELEASE_GAP_CYCLES) ?
                            P_LOCK_STABLE_CYCLES : P_RELEASE_GAP_CYCLES;
   localparam int C_MAX   = (C_MAX_A > P_SOFT_HOLD_CYCLES) ? C_MAX_A : P_SOFT_HOLD_CYCLES;
   localparam int CW      = $clog2(C_MAX) + 1;
   localparam int IW      = (P_NUM_DOMAINS > 1) ? $clog2(P_NUM_DOMAINS) : 1;

   typedef enum logic [2:0] {
      ST_ASSERT,
      ST_WAIT_LOCK,
      ST_STABLE,
      ST_RELEASE,
      ST_RUN,
      ST_SOFT_HOLD
   } state_t;

   state_t                   state, state_n;
   logic [CW-1:0]            cnt, cnt_n;
   logic [IW-1:0]            idx, idx_n;
   logic [P_NUM_DOMAINS-1:0] rst_domain_n;
   logic                     ack_n, lost_n;
   logic                     lock_meta, lock_sync;

   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge i_clk_mhz) begin
      if (i_rst_mhz) begin
         lock_meta      <= 1'b0;
         lock_sync      <= 1'b0;
         state          <= ST_ASSERT;
         cnt            <= '0;
         idx            <= '0;
         o_rst_domain   <= '1;
         o_seq_done     <= 1'b0;
         o_soft_rst_ack <= 1'b0;
         o_lock_lost    <= 1'b0;
      end else begin
         lock_meta      <= i_mmcm_locked;
         lock_sync      <= lock_meta;
         state          <= state_n;
         cnt            <= cnt_n;
         idx            <= idx_n;
         o_rst_domain   <= rst_domain_n;
         o_seq_done     <= (state_n == ST_RUN);
         o_soft_rst_ack <= ack_n;
         o_lock_lost    <= lost_n;
      end
   end

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_n      = state;
      cnt_n        = cnt;
      idx_n        = idx;
      rst_domain_n = o_rst_domain;
      ack_n        = 1'b0;
      lost_n       = 1'b0;

      case (state)
         ST_ASSERT: begin
            rst_domain_n = '1;
            cnt_n        = '0;
            idx_n        = '0;
            state_n      = ST_WAIT_LOCK;
         end

         ST_WAIT_LOCK: begin
            rst_domain_n = '1;
            if (lock_sync) begin
               state_n = ST_STABLE;
               cnt_n   = '0;
            end
         end

         ST_STABLE: begin
            if (!lock_sync) begin
               rst_domain_n = '1;
               state_n      = ST_WAIT_LOCK;
            end else if (cnt == CW'(P_LOCK_STABLE_CYCLES - 1)) begin
               state_n         = ST_RELEASE;
               cnt_n           = '0;
               idx_n           = '0;
               rst_domain_n[0] = 1'b0;
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end

         ST_RELEASE: begin
            if (!lock_sync) begin
               rst_domain_n = '1;
               lost_n       = 1'b1;
               state_n      = ST_WAIT_LOCK;
            end else if (cnt == CW'(P_RELEASE_GAP_CYCLES - 1)) begin
               cnt_n = '0;
               if (idx == IW'(P_NUM_DOMAINS - 1)) begin
                  state_n = ST_RUN;
               end else begin
                  idx_n               = idx + IW'(1);
                  rst_domain_n[idx_n] = 1'b0;
               end
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end

         ST_RUN: begin
            // Lock loss is tested first so it wins over a coincident soft request.
            if (!lock_sync) begin
               rst_domain_n = '1;
               lost_n       = 1'b1;
               state_n      = ST_WAIT_LOCK;
            end else if (i_soft_rst_req) begin
               rst_domain_n = '1;
               ack_n        = 1'b1;
               cnt_n        = '0;
               state_n      = ST_SOFT_HOLD;
            end
         end

         ST_SOFT_HOLD: begin
            if (!lock_sync) begin
               rst_domain_n = '1;
               lost_n       = 1'b1;
               state_n      = ST_WAIT_LOCK;
            end else if (cnt == CW'(P_SOFT_HOLD_CYCLES - 1)) begin
               state_n         = ST_RELEASE;
               cnt_n           = '0;
               idx_n           = '0;
               rst_domain_n[0] = 1'b0;
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end

         default: begin
            rst_domain_n = '1;
            state_n      = ST_ASSERT;
         end
      endcase
   end

endmodule

// File: tb/tb_arty_reset_sequencer.sv
// Directed bench for arty_reset_sequencer: a per-cycle vector table for power-up, soft reset
// and lock loss, then hand-written sequences for the multi-cycle corner cases.
module tb_arty_reset_sequencer;

   logic       clk;
   logic       rst;
   logic       lock;
   logic       req;
   logic       ack;
   logic [2:0] dom;
   logic       done;
   logic       lost;

   int n_cmp = 0;
   int n_err = 0;

   arty_reset_sequencer #(
      .P_NUM_DOMAINS        (3),
      .P_LOCK_STABLE_CYCLES (8),
      .P_RELEASE_GAP_CYCLES (4),
      .P_SOFT_HOLD_CYCLES   (6)
   ) dut (
      .i_clk_mhz      (clk),
      .i_rst_mhz      (rst),
      .i_mmcm_locked  (lock),
      .i_soft_rst_req (req),
      .o_soft_rst_ack (ack),
      .o_rst_domain   (dom),
      .o_seq_done     (done),
      .o_lock_lost    (lost)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Outputs packed as {dom[2:0], done, ack, lost}.
   typedef struct {
      logic       rst;
      logic       lock;
      logic       req;
      int         n;
      logic [5:0] exp;
   } vec_t;

   vec_t vecs [15];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic logic [5:0] outs();
      return {dom, done, ack, lost};
   endfunction

   // Expected outputs i cycles after domain 0 has been observed clear (gap 4, three domains).
   function automatic logic [5:0] train_exp(input int i);
      if (i < 4)       return 6'b110_000;
      else if (i < 8)  return 6'b100_000;
      else if (i < 12) return 6'b000_000;
      else             return 6'b000_100;
   endfunction

   task automatic release_train(input string name, input int start);
      for (int i = start; i <= 12; i++) begin
         step();
         check($sformatf("%s_t%0d", name, i), 32'(outs()), 32'(train_exp(i)));
      end
   endtask

   // Steps until domain 0 clears; returns cycles taken and whether o_lock_lost was ever seen.
   task automatic wait_dom0(input string name, output int cyc, output logic saw_lost);
      cyc      = 0;
      saw_lost = 1'b0;
      while (dom[0] && cyc < 200) begin
         step();
         cyc++;
         if (lost) saw_lost = 1'b1;
      end
      if (dom[0]) check({name, "_timeout"}, 32'(dom[0]), 32'd0);
   endtask

   int   cyc;
   logic saw_lost;

   initial begin
      rst  = 1'b1;
      lock = 1'b1;
      req  = 1'b0;

      vecs[0]  = '{1'b1, 1'b1, 1'b0,  2, 6'b111_000};
      vecs[1]  = '{1'b0, 1'b1, 1'b0, 10, 6'b111_000};
      vecs[2]  = '{1'b0, 1'b1, 1'b0,  4, 6'b110_000};
      vecs[3]  = '{1'b0, 1'b1, 1'b0,  4, 6'b100_000};
      vecs[4]  = '{1'b0, 1'b1, 1'b0,  4, 6'b000_000};
      vecs[5]  = '{1'b0, 1'b1, 1'b0,  3, 6'b000_100};
      vecs[6]  = '{1'b0, 1'b1, 1'b1,  1, 6'b111_010};
      vecs[7]  = '{1'b0, 1'b1, 1'b0,  5, 6'b111_000};
      vecs[8]  = '{1'b0, 1'b1, 1'b0,  4, 6'b110_000};
      vecs[9]  = '{1'b0, 1'b1, 1'b0,  4, 6'b100_000};
      vecs[10] = '{1'b0, 1'b1, 1'b0,  4, 6'b000_000};
      vecs[11] = '{1'b0, 1'b1, 1'b0,  2, 6'b000_100};
      vecs[12] = '{1'b0, 1'b0, 1'b0,  2, 6'b000_100};
      vecs[13] = '{1'b0, 1'b0, 1'b0,  1, 6'b111_001};
      vecs[14] = '{1'b0, 1'b0, 1'b0,  3, 6'b111_000};

      @(negedge clk);
      for (int i = 0; i < 15; i++) begin
         for (int k = 0; k < vecs[i].n; k++) begin
            rst  = vecs[i].rst;
            lock = vecs[i].lock;
            req  = vecs[i].req;
            step();
            check($sformatf("vec%0d_cyc%0d", i, k), 32'(outs()), 32'(vecs[i].exp));
         end
      end
      req = 1'b0;

      // Lock glitch during the stability count: no release, no lock-lost pulse, count restarts.
      lock = 1'b1;
      for (int i = 0; i < 5; i++) step();
      check("glitch_pre", 32'(outs()), 32'(6'b111_000));
      lock     = 1'b0;
      saw_lost = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         if (lost) saw_lost = 1'b1;
         check($sformatf("glitch_low%0d", i), 32'(dom), 32'(3'b111));
      end
      lock = 1'b1;
      begin
         logic sl;
         wait_dom0("glitch", cyc, sl);
         saw_lost = saw_lost | sl;
      end
      check("glitch_no_lost", 32'(saw_lost), 32'd0);
      check("glitch_restart_ge8", 32'(cyc >= 8), 32'd1);
      release_train("relock", 1);

      // Soft reset: ack next cycle, domain 0 six cycles after ack; request in ST_RELEASE ignored.
      req = 1'b1;
      step();
      req = 1'b0;
      check("soft_ack", 32'(outs()), 32'(6'b111_010));
      wait_dom0("soft", cyc, saw_lost);
      check("soft_hold_len", 32'(cyc), 32'd6);
      req = 1'b1;
      step();
      req = 1'b0;
      check("req_in_release", 32'(outs()), 32'(6'b110_000));
      release_train("soft", 2);

      // Lock loss coincident with a soft request: lock loss wins, no ack.
      lock = 1'b0;
      step();
      step();
      check("coinc_pre", 32'(outs()), 32'(6'b000_100));
      req = 1'b1;
      step();
      req = 1'b0;
      check("coinc_lost", 32'(outs()), 32'(6'b111_001));
      step();
      check("coinc_after", 32'(outs()), 32'(6'b111_000));

      // Reset pulse while domain 1 is releasing: everything re-asserts, sequence restarts.
      lock = 1'b1;
      wait_dom0("pre_rst", cyc, saw_lost);
      for (int i = 0; i < 4; i++) step();
      check("mid_rel_dom1", 32'(outs()), 32'(6'b100_000));
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("mid_rst", 32'(outs()), 32'(6'b111_000));
      wait_dom0("post_rst", cyc, saw_lost);
      check("post_rst_range", 32'(cyc >= 8 && cyc <= 12), 32'd1);
      release_train("post_rst", 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
